// File: rtl/lock_sequencer.sv
// lock_sequencer: turns debounced button pulses into datapath strobes, counts digits and tracks failed tries.
// Macro LOCK_SEQ_LOCKOUT_TIMEOUT_EN: when defined, LOCKOUT expires after LOCKOUT_CYCLES; otherwise only RST exits it.
module lock_sequencer #(
   parameter int DWL            = 8,
   parameter int DIGITS         = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 100000000
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           Open_Close,
   input  logic           Validate,
   input  logic           Change,
   input  logic           Pass,
   output logic           ShiftA,
   output logic           ShiftB,
   output logic           RSTA,
   output logic [DWL-6:0] Select,
   output logic           ALARM,
   output logic [3:0]     Tries
);

   typedef enum logic [2:0] {
      S_OPEN    = 3'd0,
      S_SET     = 3'd1,
      S_CLOSED  = 3'd2,
      S_ENTRY   = 3'd3,
      S_CHECK   = 3'd4,
      S_LOCKOUT = 3'd5
   } state_t;

   state_t     state, state_n;
   logic [3:0] count, count_n;
   logic [3:0] tries_n;
   logic       phase, phase_n;
   logic       shift_a_n, shift_b_n, rsta_n;
   logic       do_oc, do_ch, do_va;

`ifdef LOCK_SEQ_LOCKOUT_TIMEOUT_EN
   localparam int TW = $clog2(LOCKOUT_CYCLES);
   logic [TW-1:0] timer, timer_n;
`else
   logic unused_lockout_cycles;
   assign unused_lockout_cycles = ^32'(LOCKOUT_CYCLES);
`endif

   function automatic logic [3:0] sat_inc(input logic [3:0] t);
      if (t >= 4'(MAX_TRIES)) return 4'(MAX_TRIES);
      return t + 4'd1;
   endfunction

   always_comb begin
      state_n   = state;
      count_n   = count;
      tries_n   = Tries;
      phase_n   = 1'b0;
      shift_a_n = 1'b0;
      shift_b_n = 1'b0;
      rsta_n    = 1'b0;
`ifdef LOCK_SEQ_LOCKOUT_TIMEOUT_EN
      timer_n   = timer;
`endif
      // Resolve coincident pulses down to a single winner.
      do_oc = Open_Close;
      do_ch = Change & ~Open_Close;
      do_va = Validate & ~Open_Close & ~Change;
      case (state)
         S_OPEN: begin
            if (do_oc) begin
               state_n = S_CLOSED;
               rsta_n  = 1'b1;
            end else if (do_ch) begin
               state_n = S_SET;
               count_n = 4'd0;
            end
         end
         S_SET: begin
            if (do_oc || do_ch) begin
               state_n = S_OPEN;
               count_n = 4'd0;
            end else if (do_va) begin
               shift_b_n = 1'b1;
               if (count == 4'(DIGITS - 1)) begin
                  state_n = S_OPEN;
                  count_n = 4'd0;
               end else begin
                  count_n = count + 4'd1;
               end
            end
         end
         S_CLOSED: begin
            if (do_va) begin
               shift_a_n = 1'b1;
               count_n   = 4'd1;
               state_n   = (DIGITS == 1) ? S_CHECK : S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (do_oc) begin
               rsta_n  = 1'b1;
               count_n = 4'd0;
               state_n = S_CLOSED;
            end else if (do_va) begin
               shift_a_n = 1'b1;
               count_n   = count + 4'd1;
               if (count == 4'(DIGITS - 1)) state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            // First cycle lets the last shift settle; Pass is judged on the second edge.
            if (!phase) begin
               phase_n = 1'b1;
            end else begin
               count_n = 4'd0;
               if (Pass) begin
                  state_n = S_OPEN;
                  tries_n = 4'd0;
               end else begin
                  rsta_n  = 1'b1;
                  tries_n = sat_inc(Tries);
                  if (sat_inc(Tries) == 4'(MAX_TRIES)) begin
                     state_n = S_LOCKOUT;
`ifdef LOCK_SEQ_LOCKOUT_TIMEOUT_EN
                     timer_n = TW'(LOCKOUT_CYCLES - 1);
`endif
                  end else begin
                     state_n = S_CLOSED;
                  end
               end
            end
         end
         S_LOCKOUT: begin
`ifdef LOCK_SEQ_LOCKOUT_TIMEOUT_EN
            if (timer == '0) begin
               state_n = S_CLOSED;
               tries_n = 4'd0;
            end else begin
               timer_n = timer - 1'b1;
            end
`endif
         end
         default: state_n = S_OPEN;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= S_OPEN;
         count  <= 4'd0;
         Tries  <= 4'd0;
         phase  <= 1'b0;
         ShiftA <= 1'b0;
         ShiftB <= 1'b0;
         RSTA   <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         Tries  <= tries_n;
         phase  <= phase_n;
         ShiftA <= shift_a_n;
         ShiftB <= shift_b_n;
         RSTA   <= rsta_n;
      end
   end

`ifdef LOCK_SEQ_LOCKOUT_TIMEOUT_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) timer <= '0;
      else      timer <= timer_n;
   end
`endif

   assign Select = (DWL-5)'(state);
   assign ALARM  = (state == S_LOCKOUT);

endmodule
